// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and default sizing for the dual-port RAM
// Contents:
//   RAM_DATA_WIDTH / RAM_ADDR_WIDTH : default word and address widths
//   ram_state_e                     : clear-sequencer state encoding
package ram_pkg;

  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_ADDR_WIDTH = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_clr_seq.sv
// rtl/ram_clr_seq.sv - clear sequencer: zeroes the array after reset or on clr
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : request to restart the clear sequence
//   init_busy  : clear in progress, user requests are refused
//   clr_we     : write-enable for the zeroing write this cycle
//   clr_addr   : location being zeroed this cycle
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (clr) begin
      // A clr during CLEAR restarts the walk, extending the clear.
      state_d   = CLEAR;
      clr_ptr_d = '0;
    end else if (state_q == CLEAR) begin
      if (clr_ptr_q == {ADDR_WIDTH{1'b1}}) begin
        state_d   = RUN;
        clr_ptr_d = '0;
      end else begin
        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  assign init_busy = (state_q == CLEAR);
  assign clr_we    = (state_q == CLEAR);
  assign clr_addr  = clr_ptr_q;

endmodule

// File: rtl/ram_dp.sv
// rtl/ram_dp.sv - simple dual-port RAM with self-clear and write-first bypass
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   clr                       : re-clear the whole array
//   wr_enb, wr_addr, wr_data  : write port
//   rd_enb, rd_addr           : read request
//   rd_data, rd_valid         : read response, one cycle after the request
//   init_busy                 : clear in progress, requests refused
//   req_err                   : pulse, a request arrived while busy
module ram_dp
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  init_busy,
  output logic                  req_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic                  wr_acc, rd_acc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  req_err_q, req_err_d;

  ram_clr_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clr_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .init_busy(init_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // clr wins over a same-cycle request in RUN; the request is simply dropped.
  assign wr_acc = wr_enb && !init_busy && !clr;
  assign rd_acc = rd_enb && !init_busy && !clr;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wr_addr;
    mem_wdata = wr_data;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = '0;
    end else if (wr_acc) begin
      mem_we = 1'b1;
    end
  end

  // No reset on the array: the clear sequence that follows reset zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    req_err_d  = init_busy && (wr_enb || rd_enb);
    if (rd_acc) begin
      // Write-first: a same-address write this edge is forwarded.
      if (wr_acc && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem[rd_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      req_err_q  <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      req_err_q  <= req_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign req_err  = req_err_q;

endmodule

// File: doc/ram_dp.md
# ram_dp

Synchronous simple dual-port RAM with one write port and one read port, used as the device under test for the read and write agents in the RAM verification environment. After reset, and on request, it clears every location to zero with an internal sequencer. Once cleared it services independent write and read requests. Reads have a fixed one-cycle latency, and a read that collides with a write to the same address returns the new data.

## Interface
- DATA_WIDTH, 8, width of each word
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous request to re-clear the whole array
- wr_enb  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_enb  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data, valid when rd_valid=1
- rd_valid  out  1  one-cycle pulse, one cycle after an accepted read
- init_busy  out  1  clear sequence in progress; requests are not accepted
- req_err  out  1  one-cycle pulse: a wr_enb or rd_enb arrived while init_busy=1

## Operation
- FSM states:
  - CLEAR: clr_ptr walks 0..DEPTH-1 and writes 0 to one location per cycle.
  - RUN: normal service.
- Reset:
  - State goes to CLEAR with clr_ptr=0.
  - Outputs: rd_data=0, rd_valid=0, init_busy=1, req_err=0.
- CLEAR to RUN: on the cycle clr_ptr==DEPTH-1 is written. clr_ptr wraps to 0.
- RUN to CLEAR: when clr=1 is sampled. clr_ptr restarts at 0.
- clr=1 while already in CLEAR: clr_ptr restarts at 0, so the clear is extended.
- Writes:
  - In RUN, wr_enb=1 writes wr_data to mem[wr_addr] at the clock edge.
  - In CLEAR, writes are dropped.
- Reads:
  - In RUN, rd_enb=1 registers mem[rd_addr] into rd_data and sets rd_valid=1 on the next cycle.
  - rd_data holds its value when rd_valid=0.
- Collision: in RUN, if wr_enb=rd_enb=1 and wr_addr==rd_addr, rd_data returns wr_data (write-first bypass).
- Simultaneous clr and a request in RUN:
  - clr wins; the request is dropped.
  - req_err is not asserted that cycle, because init_busy was 0.
- req_err=1 on the cycle after any cycle with init_busy=1 and (wr_enb|rd_enb).
- rst_n asserted mid-clear or mid-read: state, clr_ptr and outputs return to reset values immediately.
  - Memory contents are not reset asynchronously; the following CLEAR zeroes them.
- Addresses are full-range; there is no out-of-range case. Data width is passed through unmodified.

## Timing
- Clear duration: exactly DEPTH cycles after rst_n deasserts. init_busy falls after the DEPTH-th edge.
- First request is accepted on the first edge where init_busy=0.
- Read latency: 1 cycle, request edge to rd_valid high.
- Throughput: one read and one write every cycle, back-to-back, with no bubbles.
- A write at edge N is visible to a different-address read issued at edge N+1. Same-edge reads see it only via the collision bypass.
- clr sampled at edge N: init_busy=1 from edge N. A read accepted at edge N-1 still produces rd_valid at edge N.
- req_err and rd_valid are registered, so there is no combinational path from inputs to outputs.

## Structure
- Shared package ram_pkg holds:
  - state enum ram_state_e {CLEAR, RUN};
  - the default DATA_WIDTH/ADDR_WIDTH localparams, which the agents also use for transaction field sizing.
- Sub-module ram_clr_seq contains the FSM and clr_ptr. It outputs init_busy, clr_we and clr_addr.
- The top level holds the memory array, the write mux (clear vs user), the read register and the bypass compare.

## Test plan
Defaults throughout: DATA_WIDTH=8, ADDR_WIDTH=4.
- Reset then idle: release rst_n, then:
  - init_busy=1 for 16 cycles, then 0;
  - reads of addresses 0..15 return 0x00 with rd_valid one cycle after each.
- Write/read: write 0xA5 to addr 3, then read addr 3 on the next cycle -> rd_data=0xA5, rd_valid=1 one cycle later.
- Collision: in the same cycle, write 0x3C to addr 7 and read addr 7 -> rd_data=0x3C. A read of addr 7 on the next cycle -> 0x3C.
- Back-to-back: read addrs 0..15 on 16 consecutive cycles after writing data=addr+0x10 -> rd_valid high for 16 cycles with data 0x10..0x1F in order.
- Request during clear: rd_enb=1 and wr_enb=1 (0xFF to addr 0) on cycle 5 after reset ->
  - req_err pulses once;
  - no rd_valid;
  - a later read of addr 0 returns 0x00.
- clr mid-run and reset mid-clear:
  - write 0x55 to addr 9, pulse clr -> 16 busy cycles, then addr 9 reads 0x00;
  - assert rst_n low during cycle 8 of a clear -> init_busy restarts a full 16-cycle clear.
